flatten_buffer_mc: RTL and testbench
====================================

# flatten_buffer_mc

Parametrised multi-lane flatten buffer that sits between the last convolution/pooling stage and the fully-connected layer. It accepts N_CH signed words per beat over a valid/ready handshake until DEPTH words are stored, then presents the whole frame in parallel to the FC stage. It holds the frame until the consumer acknowledges it, then re-arms for the next frame without a reset.

## Interface
- DATA_W, 22: signed word width.
- DEPTH, 225: words per frame. DEPTH % N_CH must be 0; otherwise `$error` at elaboration.
- N_CH, 1: words accepted per beat (lanes).
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- i_data_valid  in  1  beat valid.
- o_data_ready  out  1  buffer can accept a beat.
- i_data_in  in  N_CH x DATA_W signed  lane k holds word (base + k).
- i_frame_ack  in  1  consumer has taken the frame; releases FULL.
- o_buffer_full  out  1  complete frame present.
- o_word_count  out  $clog2(DEPTH+1)  words stored in the current frame.
- o_flattened_data  out  DEPTH x DATA_W signed  parallel frame contents.
- o_overflow  out  1  sticky overflow flag; see Configuration.

## Operation
- Storage is a register array of DEPTH words. o_flattened_data is driven directly from the array.
- A beat is accepted when i_data_valid && o_data_ready. Lane k is written to address wr_addr + k. wr_addr then advances by N_CH.
- FSM states:
  - IDLE (wr_addr = 0): an accepted beat writes lanes and moves to FILL. If N_CH == DEPTH, it moves directly to FULL.
  - FILL: an accepted beat writes lanes. If wr_addr == DEPTH - N_CH, move to FULL; otherwise advance wr_addr.
  - FULL: o_data_ready = 0 and no writes occur. i_frame_ack moves to IDLE and sets wr_addr = 0.
- o_data_ready = (state != FULL), decoded combinationally from the registered state.
- o_word_count equals wr_addr in IDLE/FILL and DEPTH in FULL.
- Memory is not cleared on ack. Old words stay visible until overwritten by the next frame.
- i_frame_ack is ignored in IDLE/FILL.
- In FULL, when i_frame_ack and i_data_valid occur together, the ack takes effect and the beat is not accepted (ready is low that cycle). The beat can be accepted on the following cycle.
- i_data_valid with ready low is dropped. The source must hold data until ready.

## Timing
- Reset values: state IDLE, wr_addr 0, every memory word 0, o_buffer_full 0, o_data_ready 1, o_word_count 0, o_overflow 0.
- Reset mid-frame or while FULL discards the frame. All reset values apply on the next cycle.
- Write latency is 1 cycle: a word accepted at edge t is visible on o_flattened_data after edge t.
- The final beat is accepted at edge t. o_buffer_full = 1 and o_data_ready = 0 from edge t onward, with no bubble.
- Ack is sampled at edge t. o_buffer_full = 0 and o_data_ready = 1 after edge t.
- Sustained throughput is N_CH words/cycle. Minimum frame period is DEPTH/N_CH + 1 cycles (fill beats plus one ack cycle).

## Configuration
- FLATTEN_OVERFLOW_DETECT_EN defined:
  - o_overflow is set when i_data_valid = 1 in FULL and i_frame_ack = 0 in the same cycle.
  - Once set, it stays high until rst or an accepted i_frame_ack clears it. Set and clear take effect after the sampling edge.
- FLATTEN_OVERFLOW_DETECT_EN undefined: o_overflow is tied to 0 and no detection logic is built. All other behaviour is identical.

## Test plan
- Default params, 225 consecutive beats with values 1..225 -> o_buffer_full rises after the 225th edge; word[i] = i+1; o_word_count = 225; ready = 0.
- N_CH=3, DEPTH=9: three beats {1,2,3},{4,5,6},{7,8,9} -> frame 1..9, full after the 3rd beat. Then ack -> count 0, ready 1, frame still reads 1..9.
- Valid toggled 50% mid-fill, plus a reset after 100 words -> only handshaken words are stored. After reset, all words are 0, count 0, state IDLE.
- FULL held for 5 cycles with valid high, then ack and valid together -> no writes while FULL; the ack cycle beat is dropped; the next beat lands at word 0. o_overflow = 1 (macro on) or 0 (macro off), and clears on ack.
- Ack pulsed during IDLE/FILL -> no effect on count, state or data.
- N_CH = DEPTH = 4: a single beat -> FULL immediately after that edge.

Source files
------------

// File: rtl/flatten_buffer_mc.sv
// -----------------------------------------------------------------------------
// flatten_buffer_mc
//
// Multi-lane flatten buffer between the last conv/pool stage and the FC layer.
// Collects N_CH signed words per handshaken beat until DEPTH words are held,
// then presents the whole frame in parallel and holds it until the consumer
// acknowledges. After the ack it re-arms for the next frame without a reset.
// Stored words are not cleared on ack; they remain visible until overwritten.
//
// Parameters
//   DATA_W  signed word width
//   DEPTH   words per frame (must be a multiple of N_CH)
//   N_CH    words accepted per beat (lanes)
//
// Ports
//   clk               clock, all logic on posedge
//   rst               synchronous active-high reset (control and storage)
//   i_data_valid      beat valid
//   o_data_ready      buffer can accept a beat (low only while FULL)
//   i_data_in         N_CH lanes, lane k is written to word (wr_addr + k)
//   i_frame_ack       consumer has taken the frame; releases FULL
//   o_buffer_full     complete frame present
//   o_word_count      words stored in the current frame
//   o_flattened_data  parallel frame contents, word i at index i
//   o_overflow        sticky: valid seen while FULL without ack
//
// Build option
//   FLATTEN_OVERFLOW_DETECT_EN  when defined, builds the sticky overflow
//                               detector; otherwise o_overflow is tied to 0.
// -----------------------------------------------------------------------------
module flatten_buffer_mc #(
    parameter int DATA_W = 22,
    parameter int DEPTH  = 225,
    parameter int N_CH   = 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_data_valid,
    output logic                               o_data_ready,
    input  logic signed [N_CH-1:0][DATA_W-1:0]  i_data_in,
    input  logic                               i_frame_ack,
    output logic                               o_buffer_full,
    output logic [$clog2(DEPTH+1)-1:0]         o_word_count,
    output logic signed [DEPTH-1:0][DATA_W-1:0] o_flattened_data,
    output logic                               o_overflow
);

    localparam int AW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - N_CH);
    localparam logic [AW-1:0] STEP      = AW'(N_CH);
    localparam logic [AW-1:0] FULL_CNT  = AW'(DEPTH);

    if ((DEPTH % N_CH) != 0) begin : g_depth_check
        $error("flatten_buffer_mc: DEPTH (%0d) must be a multiple of N_CH (%0d)", DEPTH, N_CH);
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t                             state_q, state_d;
    logic [AW-1:0]                      wr_addr_q, wr_addr_d;
    logic signed [DEPTH-1:0][DATA_W-1:0] mem_q;
    logic                               beat_accept;

    // Ready is decoded from the registered state, so a beat presented in the
    // FULL cycle that carries the ack is dropped rather than accepted.
    assign beat_accept = i_data_valid && (state_q != S_FULL);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wr_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            wr_addr_q <= wr_addr_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        unique case (state_q)
            S_IDLE, S_FILL: begin
                if (beat_accept) begin
                    // In IDLE wr_addr is 0, so N_CH == DEPTH goes straight to FULL.
                    if (wr_addr_q == LAST_ADDR) begin
                        state_d = S_FULL;
                    end else begin
                        state_d   = S_FILL;
                        wr_addr_d = wr_addr_q + STEP;
                    end
                end
            end
            S_FULL: begin
                if (i_frame_ack) begin
                    state_d   = S_IDLE;
                    wr_addr_d = '0;
                end
            end
            default: begin
                state_d   = S_IDLE;
                wr_addr_d = '0;
            end
        endcase
    end

    // Output decode
    always_comb begin
        o_data_ready  = (state_q != S_FULL);
        o_buffer_full = (state_q == S_FULL);
        o_word_count  = (state_q == S_FULL) ? FULL_CNT : wr_addr_q;
    end

    // Frame storage: each word compares its own index against every lane's
    // target address, so no variable-width array index is needed.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '0;
        end else if (beat_accept) begin
            for (int i = 0; i < DEPTH; i++) begin
                for (int k = 0; k < N_CH; k++) begin
                    if ((wr_addr_q + AW'(k)) == AW'(i)) begin
                        mem_q[i] <= i_data_in[k];
                    end
                end
            end
        end
    end

    assign o_flattened_data = mem_q;

`ifdef FLATTEN_OVERFLOW_DETECT_EN
    logic ovf_q, ovf_d;

    // Ack wins over a simultaneous valid: the frame is released, not overrun.
    always_comb begin
        ovf_d = ovf_q;
        if (state_q == S_FULL) begin
            if (i_frame_ack) begin
                ovf_d = 1'b0;
            end else if (i_data_valid) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign o_overflow = ovf_q;
`else
    assign o_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_flatten_buffer_mc.sv
module tb_flatten_buffer_mc;

    localparam int DW = 22;
`ifdef FLATTEN_OVERFLOW_DETECT_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // u0: default parameters (DEPTH 225, N_CH 1)
    logic                          v0, ack0, rdy0, full0, ovf0;
    logic signed [0:0][DW-1:0]     d0;
    logic [7:0]                    cnt0;
    logic signed [224:0][DW-1:0]   flat0;
    // u1: DEPTH 9, N_CH 3
    logic                          v1, ack1, rdy1, full1, ovf1;
    logic signed [2:0][DW-1:0]     d1;
    logic [3:0]                    cnt1;
    logic signed [8:0][DW-1:0]     flat1;
    // u2: DEPTH 4, N_CH 4
    logic                          v2, ack2, rdy2, full2, ovf2;
    logic signed [3:0][DW-1:0]     d2;
    logic [2:0]                    cnt2;
    logic signed [3:0][DW-1:0]     flat2;

    flatten_buffer_mc #(.DATA_W(DW), .DEPTH(225), .N_CH(1)) u0 (
        .clk(clk), .rst(rst), .i_data_valid(v0), .o_data_ready(rdy0),
        .i_data_in(d0), .i_frame_ack(ack0), .o_buffer_full(full0),
        .o_word_count(cnt0), .o_flattened_data(flat0), .o_overflow(ovf0));

    flatten_buffer_mc #(.DATA_W(DW), .DEPTH(9), .N_CH(3)) u1 (
        .clk(clk), .rst(rst), .i_data_valid(v1), .o_data_ready(rdy1),
        .i_data_in(d1), .i_frame_ack(ack1), .o_buffer_full(full1),
        .o_word_count(cnt1), .o_flattened_data(flat1), .o_overflow(ovf1));

    flatten_buffer_mc #(.DATA_W(DW), .DEPTH(4), .N_CH(4)) u2 (
        .clk(clk), .rst(rst), .i_data_valid(v2), .o_data_ready(rdy2),
        .i_data_in(d2), .i_frame_ack(ack2), .o_buffer_full(full2),
        .o_word_count(cnt2), .o_flattened_data(flat2), .o_overflow(ovf2));

    typedef struct {
        int          dut;
        int          addr;
        logic [DW-1:0] val;
    } sb_t;

    sb_t sb[$];
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int dut, input int addr, input logic [DW-1:0] val);
        sb_t e;
        e.dut  = dut;
        e.addr = addr;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic drain();
        sb_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.dut)
                0:       chk($sformatf("u0_word%0d", e.addr), 64'(flat0[e.addr]), 64'(e.val));
                1:       chk($sformatf("u1_word%0d", e.addr), 64'(flat1[e.addr]), 64'(e.val));
                default: chk($sformatf("u2_word%0d", e.addr), 64'(flat2[e.addr]), 64'(e.val));
            endcase
        end
    endtask

    initial begin
        int exp_cnt;
        int j;
        logic [DW-1:0] w;

        rst = 1'b1;
        v0 = 1'b0; ack0 = 1'b0; d0 = '0;
        v1 = 1'b0; ack1 = 1'b0; d1 = '0;
        v2 = 1'b0; ack2 = 1'b0; d2 = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_full0", 64'(full0), 64'(0));
        chk("rst_rdy0", 64'(rdy0), 64'(1));
        chk("rst_cnt0", 64'(cnt0), 64'(0));
        chk("rst_ovf0", 64'(ovf0), 64'(0));
        chk("rst_mem0", 64'(|flat0), 64'(0));
        chk("rst_rdy1", 64'(rdy1), 64'(1));
        chk("rst_mem1", 64'(|flat1), 64'(0));

        // Ack in IDLE has no effect
        ack0 = 1'b1;
        tick();
        ack0 = 1'b0;
        chk("idle_ack_cnt0", 64'(cnt0), 64'(0));
        chk("idle_ack_full0", 64'(full0), 64'(0));
        chk("idle_ack_rdy0", 64'(rdy0), 64'(1));

        // Full default frame: 225 consecutive beats with values 1..225
        for (int i = 0; i < 225; i++) begin
            v0 = 1'b1;
            w = DW'(i + 1);
            d0[0] = w;
            push(0, i, w);
            tick();
            chk($sformatf("fill_cnt0_%0d", i), 64'(cnt0), 64'(i + 1));
            chk($sformatf("fill_full0_%0d", i), 64'(full0), 64'(i == 224));
        end
        v0 = 1'b0;
        chk("full_rdy0", 64'(rdy0), 64'(0));
        chk("full_cnt0", 64'(cnt0), 64'(225));
        drain();

        // FULL held 5 cycles with valid high: no writes, overflow per build
        v0 = 1'b1;
        d0[0] = DW'(999);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_full0", 64'(full0), 64'(1));
            chk("hold_rdy0", 64'(rdy0), 64'(0));
            chk("hold_ovf0", 64'(ovf0), 64'(OVF_EXP));
            chk("hold_w0", 64'(flat0[0]), 64'(1));
            chk("hold_w224", 64'(flat0[224]), 64'(225));
        end
        // Ack and valid together: ack wins, beat dropped
        ack0 = 1'b1;
        d0[0] = DW'(777);
        tick();
        ack0 = 1'b0;
        chk("ack_full0", 64'(full0), 64'(0));
        chk("ack_rdy0", 64'(rdy0), 64'(1));
        chk("ack_cnt0", 64'(cnt0), 64'(0));
        chk("ack_ovf0", 64'(ovf0), 64'(0));
        chk("ack_drop_w0", 64'(flat0[0]), 64'(1));
        // Next beat lands at word 0
        d0[0] = DW'(555);
        push(0, 0, DW'(555));
        tick();
        v0 = 1'b0;
        chk("rearm_cnt0", 64'(cnt0), 64'(1));
        chk("rearm_w1_old", 64'(flat0[1]), 64'(2));

        // 50% valid mid-fill with ack pulses ignored in FILL, up to 100 words
        exp_cnt = 1;
        j = 0;
        while (exp_cnt < 100 && j < 1000) begin
            v0   = 1'($urandom_range(0, 1));
            ack0 = ((j % 7) == 3);
            w    = DW'(1000 + j);
            d0[0] = w;
            if (v0) begin
                push(0, exp_cnt, w);
                exp_cnt++;
            end
            tick();
            chk("rand_cnt0", 64'(cnt0), 64'(exp_cnt));
            chk("rand_full0", 64'(full0), 64'(0));
            j++;
        end
        v0 = 1'b0;
        ack0 = 1'b0;
        chk("rand_reached100", 64'(exp_cnt), 64'(100));
        drain();

        // Reset mid-frame discards everything
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_mem0", 64'(|flat0), 64'(0));
        chk("midrst_cnt0", 64'(cnt0), 64'(0));
        chk("midrst_rdy0", 64'(rdy0), 64'(1));
        chk("midrst_full0", 64'(full0), 64'(0));

        // N_CH=3, DEPTH=9: frame 1..9 in three beats
        for (int b = 0; b < 3; b++) begin
            v1 = 1'b1;
            for (int k = 0; k < 3; k++) begin
                w = DW'(3 * b + k + 1);
                d1[k] = w;
                push(1, 3 * b + k, w);
            end
            tick();
            chk($sformatf("u1_full_b%0d", b), 64'(full1), 64'(b == 2));
            chk($sformatf("u1_cnt_b%0d", b), 64'(cnt1), 64'(3 * (b + 1)));
            chk($sformatf("u1_rdy_b%0d", b), 64'(rdy1), 64'(b != 2));
        end
        v1 = 1'b0;
        drain();
        ack1 = 1'b1;
        tick();
        ack1 = 1'b0;
        chk("u1_ack_cnt", 64'(cnt1), 64'(0));
        chk("u1_ack_rdy", 64'(rdy1), 64'(1));
        chk("u1_ack_full", 64'(full1), 64'(0));
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("u1_keep_w%0d", i), 64'(flat1[i]), 64'(DW'(i + 1)));
        end
        // Second frame with negative values
        for (int b = 0; b < 3; b++) begin
            v1 = 1'b1;
            for (int k = 0; k < 3; k++) begin
                w = DW'(-(3 * b + k + 1));
                d1[k] = w;
                push(1, 3 * b + k, w);
            end
            tick();
        end
        v1 = 1'b0;
        chk("u1_neg_full", 64'(full1), 64'(1));
        drain();

        // N_CH = DEPTH = 4: a single beat fills the frame
        chk("u2_pre_rdy", 64'(rdy2), 64'(1));
        v2 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            w = DW'(10 * (k + 1));
            d2[k] = w;
            push(2, k, w);
        end
        tick();
        v2 = 1'b0;
        chk("u2_full", 64'(full2), 64'(1));
        chk("u2_rdy", 64'(rdy2), 64'(0));
        chk("u2_cnt", 64'(cnt2), 64'(4));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
